// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state type and the wait-counter width.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane data, fault
// detection, and extraction/extension of load data from a RAM word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] write_data,
  input  logic [31:0] ram_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        fault
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    byte_en    = 4'b0000;
    store_word = 32'h0;
    load_value = 32'h0;
    fault      = 1'b0;
    lane_byte  = ram_word[{addr_lo, 3'b000} +: 8];
    lane_half  = ram_word[{addr_lo[1], 4'b0000} +: 16];
    // Store data is replicated across lanes; byte_en picks the live ones.
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        store_word = {4{write_data[7:0]}};
        load_value = {{24{lane_byte[7]}}, lane_byte};
      end
      F3_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
        load_value = {{16{lane_half[15]}}, lane_half};
        fault      = addr_lo[0];
      end
      F3_W: begin
        byte_en    = 4'b1111;
        store_word = write_data;
        load_value = ram_word;
        fault      = |addr_lo;
      end
      F3_BU: begin
        load_value = {24'h0, lane_byte};
        fault      = is_store;
      end
      F3_HU: begin
        load_value = {16'h0, lane_half};
        fault      = is_store | addr_lo[0];
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_lsu.sv
// Load/store stage: word-organised RAM with byte/half/word access, a
// configurable access latency signalled through stall, and a done pulse.
module data_memory_lsu
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // The request cycle already counts as one stall cycle, so BUSY lasts
  // WAIT_CYCLES cycles and the counter holds the BUSY cycles still to go.
  localparam logic [WAIT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              store_q, store_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              mis_q, mis_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic          in_idle, req, access, ram_we, fault;
  logic [2:0]    sel_f3;
  logic          sel_store;
  logic [AW+1:0] sel_addr;
  logic [31:0]   sel_wdata, ram_word, store_word, load_value;
  logic [3:0]    byte_en;
  logic          addr_unused;

  assign addr_unused = ^addr[31:AW+2];

  // In IDLE the live request drives the lane logic (fault check, and the
  // zero-latency access); afterwards the captured request does.
  assign in_idle   = (state_q == IDLE);
  assign req       = mem_read | mem_write;
  assign sel_f3    = in_idle ? funct3 : f3_q;
  assign sel_store = in_idle ? mem_write : store_q;
  assign sel_addr  = in_idle ? addr[AW+1:0] : addr_q;
  assign sel_wdata = in_idle ? write_data : wdata_q;
  assign ram_word  = ram[sel_addr[AW+1:2]];

  lsu_lane_align u_align (
    .funct3     (sel_f3),
    .is_store   (sel_store),
    .addr_lo    (sel_addr[1:0]),
    .write_data (sel_wdata),
    .ram_word   (ram_word),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_value (load_value),
    .fault      (fault)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    store_d     = store_q;
    read_data_d = read_data_q;
    mis_d       = 1'b0;
    stall       = 1'b0;
    access      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !reset) begin
          if (fault) begin
            mis_d = 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = addr[AW+1:0];
            wdata_d = write_data;
            f3_d    = funct3;
            store_d = mem_write;
            cnt_d   = CNT_INIT;
            if (WAIT_CYCLES == 0) begin
              access  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = BUSY;
            end
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (access && !sel_store) read_data_d = load_value;
  end

  assign ram_we = access & sel_store;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      store_q     <= 1'b0;
      read_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      store_q     <= store_d;
      read_data_q <= read_data_d;
      mis_q       <= mis_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[sel_addr[AW+1:2]][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign read_data  = read_data_q;
  assign done       = (state_q == DONE);
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: three instances (latency 1, 0, 15) driven by a
// directed vector table, a reset-abort sequence and random accesses vs a byte model.
module tb_data_memory_lsu;

  localparam int NI     = 3;
  localparam int DEPTH  = 256;
  localparam int MBYTES = 4 * DEPTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        mem_read   [NI];
  logic        mem_write  [NI];
  logic [2:0]  funct3     [NI];
  logic [31:0] addr       [NI];
  logic [31:0] write_data [NI];
  logic [31:0] read_data  [NI];
  logic        stall      [NI];
  logic        done       [NI];
  logic        misaligned [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      data_memory_lsu #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES ((gi == 0) ? 1 : ((gi == 1) ? 0 : 15))
      ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read[gi]),
        .mem_write  (mem_write[gi]),
        .funct3     (funct3[gi]),
        .addr       (addr[gi]),
        .write_data (write_data[gi]),
        .read_data  (read_data[gi]),
        .stall      (stall[gi]),
        .done       (done[gi]),
        .misaligned (misaligned[gi])
      );
    end
  endgenerate

  // Behavioural model: a flat byte array per instance plus the last load result.
  logic [7:0]  mdl    [NI][MBYTES];
  logic [31:0] mdl_rd [NI];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_fault;
  } vec_t;
  vec_t vecs [18];

  function automatic int acc_size(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (wr) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return ok && ((a % 32'(acc_size(f3))) == 0);
  endfunction

  task automatic model_apply(input int k, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
    int b, sz;
    logic [31:0] v;
    if (!legal(wr, f3, a)) return;
    b  = int'(a % MBYTES);
    sz = acc_size(f3);
    if (wr) begin
      for (int i = 0; i < sz; i++) mdl[k][b+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mdl[k][b+i];
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      mdl_rd[k] = v;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one request at a negedge, holds it until done (or for one cycle if
  // no stall), then watches three more cycles. Samples 1 time unit after negedge.
  task automatic access(input int k, input bit wr, input bit rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int stall_n, output int done_at, output int done_n,
                        output int mis_at, output int mis_n, output logic [31:0] rdata);
    int ended;
    stall_n = 0; done_at = -1; done_n = 0; mis_at = -1; mis_n = 0; ended = -1;
    rdata = 32'h0;
    @(negedge clk);
    mem_write[k] = wr; mem_read[k] = rd; funct3[k] = f3; addr[k] = a; write_data[k] = wd;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall[k]) stall_n++;
      if (misaligned[k]) begin
        mis_n++;
        if (mis_at < 0) mis_at = c;
      end
      if (done[k]) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          rdata   = read_data[k];
        end
      end
      if (ended < 0 && (done[k] || (c == 0 && !stall[k]))) ended = c;
      @(negedge clk);
      if (ended >= 0) begin
        mem_write[k] = 1'b0;
        mem_read[k]  = 1'b0;
      end
      if (ended >= 0 && c >= ended + 3) break;
    end
    if (ended < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout inst %0d: no completion within 40 cycles", k);
      mem_write[k] = 1'b0;
      mem_read[k]  = 1'b0;
    end
    if (done_at < 0) begin
      #1;
      rdata = read_data[k];
    end
  endtask

  task automatic run_check(input int k, input bit wr, input bit rd, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit exp_fault, input string tag);
    int s_n, d_at, d_n, m_at, m_n;
    logic [31:0] r;
    int w = (k == 0) ? 1 : ((k == 1) ? 0 : 15);
    access(k, wr, rd, f3, a, wd, s_n, d_at, d_n, m_at, m_n, r);
    $display("%s inst=%0d wr=%0d rd=%0d f3=%0d addr=%h wdata=%h read_data=%h stall=%0d done_at=%0d mis_at=%0d",
             tag, k, wr, rd, f3, a, wd, r, s_n, d_at, m_at);
    check({tag, " read_data"}, r, exp_rd);
    if (exp_fault) begin
      check({tag, " misaligned_cycle"}, 32'(m_at), 32'd1);
      check({tag, " misaligned_count"}, 32'(m_n), 32'd1);
      check({tag, " stall_count"}, 32'(s_n), 32'd0);
      check({tag, " done_count"}, 32'(d_n), 32'd0);
    end else begin
      check({tag, " stall_count"}, 32'(s_n), 32'(w + 1));
      check({tag, " done_cycle"}, 32'(d_at), 32'(w + 1));
      check({tag, " done_count"}, 32'(d_n), 32'd1);
      check({tag, " misaligned_count"}, 32'(m_n), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          wr, rd;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    logic [2:0]  legal_f3 [5];

    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int k = 0; k < NI; k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; funct3[k] = 3'd0;
      addr[k] = 32'h0; write_data[k] = 32'h0; mdl_rd[k] = 32'h0;
    end

    vecs[0]  = '{1, 0, 3'd2, 32'h10,  32'hDEADBEEF, 32'h00000000, 0};
    vecs[1]  = '{0, 1, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1, 0, 3'd0, 32'h12,  32'h0000005A, 32'hDEADBEEF, 0};
    vecs[3]  = '{0, 1, 3'd2, 32'h10,  32'h0,        32'hDE5ABEEF, 0};
    vecs[4]  = '{0, 1, 3'd0, 32'h13,  32'h0,        32'hFFFFFFDE, 0};
    vecs[5]  = '{0, 1, 3'd4, 32'h13,  32'h0,        32'h000000DE, 0};
    vecs[6]  = '{0, 1, 3'd1, 32'h12,  32'h0,        32'hFFFFDE5A, 0};
    vecs[7]  = '{0, 1, 3'd2, 32'h11,  32'h0,        32'hFFFFDE5A, 1};
    vecs[8]  = '{1, 0, 3'd1, 32'h13,  32'h00001234, 32'hFFFFDE5A, 1};
    vecs[9]  = '{0, 1, 3'd2, 32'h10,  32'h0,        32'hDE5ABEEF, 0};
    vecs[10] = '{1, 0, 3'd2, 32'h400, 32'h12345678, 32'hDE5ABEEF, 0};
    vecs[11] = '{0, 1, 3'd2, 32'h000, 32'h0,        32'h12345678, 0};
    vecs[12] = '{1, 1, 3'd2, 32'h14,  32'hCAFEF00D, 32'h12345678, 0};
    vecs[13] = '{0, 1, 3'd2, 32'h14,  32'h0,        32'hCAFEF00D, 0};
    vecs[14] = '{0, 1, 3'd3, 32'h14,  32'h0,        32'hCAFEF00D, 1};
    vecs[15] = '{1, 0, 3'd4, 32'h15,  32'h0,        32'hCAFEF00D, 1};
    vecs[16] = '{0, 1, 3'd5, 32'h16,  32'h0,        32'h0000CAFE, 0};
    vecs[17] = '{0, 1, 3'd0, 32'h15,  32'h0,        32'hFFFFFFF0, 0};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset inst%0d read_data", k), read_data[k], 32'h0);
      check($sformatf("reset inst%0d stall", k), 32'(stall[k]), 32'd0);
      check($sformatf("reset inst%0d done", k), 32'(done[k]), 32'd0);
      check($sformatf("reset inst%0d misaligned", k), 32'(misaligned[k]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Known contents for the 16 words the random phase uses.
    for (int k = 0; k < NI; k++) begin
      for (int w = 0; w < 16; w++) begin
        model_apply(k, 1'b1, 3'd2, 32'(4 * w), 32'h0);
        run_check(k, 1'b1, 1'b0, 3'd2, 32'(4 * w), 32'h0, 32'h0, 1'b0,
                  $sformatf("init%0d.%0d", k, w));
      end
    end

    for (int i = 0; i < 18; i++) begin
      model_apply(0, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd);
      run_check(0, vecs[i].wr, vecs[i].rd, vecs[i].f3, vecs[i].a, vecs[i].wd,
                vecs[i].exp_rd, vecs[i].exp_fault, $sformatf("vec%0d", i));
    end

    // Reset in the middle of a store's BUSY cycle must abort the write.
    @(negedge clk);
    mem_write[0] = 1'b1; mem_read[0] = 1'b0; funct3[0] = 3'd2;
    addr[0] = 32'h20; write_data[0] = 32'hFFFFFFFF;
    #1;
    check("rstseq stall_request", 32'(stall[0]), 32'd1);
    @(negedge clk);
    #1;
    check("rstseq stall_busy", 32'(stall[0]), 32'd1);
    reset = 1'b1;
    #1;
    check("rstseq read_data", read_data[0], 32'h0);
    check("rstseq stall", 32'(stall[0]), 32'd0);
    check("rstseq done", 32'(done[0]), 32'd0);
    check("rstseq misaligned", 32'(misaligned[0]), 32'd0);
    $display("rstseq inst=0 SW addr=00000020 aborted by reset, read_data=%h", read_data[0]);
    mem_write[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < NI; k++) mdl_rd[k] = 32'h0;
    run_check(0, 1'b0, 1'b1, 3'd2, 32'h20, 32'h0, 32'h0, 1'b0, "rstseq_lw");

    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < ((k == 2) ? 30 : 60); i++) begin
        wr = 1'($urandom_range(0, 1));
        rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
        a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
        a[1:0] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(0, 3));
        wd = $urandom;
        model_apply(k, wr, f3, a, wd);
        run_check(k, wr, rd, f3, a, wd, mdl_rd[k], !legal(wr, f3, a),
                  $sformatf("rnd%0d.%0d", k, i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
